// File: rtl/operand_skew_feeder_if.sv
// Operand skew feeder bus: the producer side presents operand vector pairs
// and the stall, and the feeder side returns the skewed lanes and tile status.
interface operand_skew_feeder_if #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 32
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic [ARR_SIZE*DATA_W-1:0]   in_act;
  logic [ARR_SIZE*DATA_W-1:0]   in_wt;
  logic                         mac_stall;
  logic [ARR_SIZE*DATA_W-1:0]   act_out;
  logic [ARR_SIZE*DATA_W-1:0]   wt_out;
  logic [ARR_SIZE-1:0]          lane_valid;
  logic                         tile_done;
  logic                         busy;
  logic [15:0]                  vec_count;

  modport master (
    output in_valid, in_last, in_act, in_wt, mac_stall,
    input  in_ready, act_out, wt_out, lane_valid, tile_done, busy, vec_count
  );

  modport slave (
    input  in_valid, in_last, in_act, in_wt, mac_stall,
    output in_ready, act_out, wt_out, lane_valid, tile_done, busy, vec_count
  );
endinterface

// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: takes one activation/weight vector pair per accepted
// cycle and presents it to a systolic array edge with lane i delayed by i
// enabled cycles, then flushes the diagonal and flags the end of the tile.
module operand_skew_feeder #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  operand_skew_feeder_if.slave io
);

  localparam int               CNT_W      = $clog2(ARR_SIZE);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(ARR_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNT_W-1:0]           r_flush_cnt;
  logic [CNT_W-1:0]           w_flush_cnt_nxt;
  logic [15:0]                r_vec_cnt;
  logic [15:0]                w_vec_cnt_nxt;
  logic                       r_tile_done;
  logic                       w_tile_done_nxt;
  logic                       w_en;
  logic                       w_ready;
  logic                       w_accept;
  logic [ARR_SIZE*DATA_W-1:0] w_act_out;
  logic [ARR_SIZE*DATA_W-1:0] w_wt_out;
  logic [ARR_SIZE-1:0]        w_lane_valid;

  // A stalled MAC array freezes everything; no input is taken while flushing.
  assign w_en     = ~io.mac_stall;
  assign w_ready  = w_en && (r_state != ST_FLUSH);
  assign w_accept = io.in_valid && w_ready;

  // Next-state, flush countdown, vector count and tile_done pulse.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_vec_cnt_nxt   = r_vec_cnt;
    w_tile_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_vec_cnt_nxt = 16'd1;
          if (io.in_last) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
          end else begin
            w_state_nxt = ST_STREAM;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (w_accept) begin
          w_vec_cnt_nxt = (r_vec_cnt == 16'hFFFF) ? r_vec_cnt : r_vec_cnt + 16'd1;
          if (io.in_last) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
          end else begin
            w_state_nxt = ST_STREAM;
          end
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        // The countdown hits zero exactly when the last element reaches the
        // final lane, so tile_done lines up with it.
        if (r_flush_cnt <= CNT_W'(1)) begin
          w_flush_cnt_nxt = '0;
          w_tile_done_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  // Control state register; holds completely while the array is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_vec_cnt   <= 16'd0;
      r_tile_done <= 1'b0;
    end else if (w_en) begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_vec_cnt   <= w_vec_cnt_nxt;
      r_tile_done <= w_tile_done_nxt;
    end
  end

  for (genvar g = 0; g < ARR_SIZE; g++) begin : g_lane
    logic [DATA_W-1:0] r_act_sr [0:g];
    logic [DATA_W-1:0] r_wt_sr  [0:g];
    logic              r_vld_sr [0:g];
    logic [DATA_W-1:0] w_act_head;
    logic [DATA_W-1:0] w_wt_head;

    // A non-accepting enabled edge injects a zero bubble at the lane head.
    assign w_act_head = w_accept ? io.in_act[g*DATA_W +: DATA_W] : '0;
    assign w_wt_head  = w_accept ? io.in_wt[g*DATA_W +: DATA_W]  : '0;

    // Lane g is a chain of g+1 stages; data and valid shift together.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= g; j++) begin
          r_act_sr[j] <= '0;
          r_wt_sr[j]  <= '0;
          r_vld_sr[j] <= 1'b0;
        end
      end else if (w_en) begin
        r_act_sr[0] <= w_act_head;
        r_wt_sr[0]  <= w_wt_head;
        r_vld_sr[0] <= w_accept;
        for (int j = 1; j <= g; j++) begin
          r_act_sr[j] <= r_act_sr[j-1];
          r_wt_sr[j]  <= r_wt_sr[j-1];
          r_vld_sr[j] <= r_vld_sr[j-1];
        end
      end
    end

    assign w_act_out[g*DATA_W +: DATA_W] = r_act_sr[g];
    assign w_wt_out[g*DATA_W +: DATA_W]  = r_wt_sr[g];
    assign w_lane_valid[g]               = r_vld_sr[g];
  end

  assign io.in_ready   = w_ready;
  assign io.act_out    = w_act_out;
  assign io.wt_out     = w_wt_out;
  assign io.lane_valid = w_lane_valid;
  assign io.tile_done  = r_tile_done;
  assign io.busy       = (r_state != ST_IDLE);
  assign io.vec_count  = r_vec_cnt;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Bench for operand_skew_feeder: directed tiles plus random traffic checked
// every cycle against a history-based model of the skewed array edge.
module tb_operand_skew_feeder;
  localparam int ARR = 4;
  localparam int DW  = 32;
  localparam int W   = ARR * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  operand_skew_feeder_if #(.ARR_SIZE(ARR), .DATA_W(DW)) ifc ();

  operand_skew_feeder #(.ARR_SIZE(ARR), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (ifc.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: n counts enabled edges; hist[k] is what entered the array heads at
  // enabled edge k, so lane i after edge n shows hist[n-i].
  int          n = 0;
  int          rst_base = 0;
  int          flush_until = -1;
  bit          streaming = 1'b0;
  logic [15:0] m_vcnt = 16'd0;
  logic [W-1:0] h_act [0:63];
  logic [W-1:0] h_wt  [0:63];
  bit           h_vld [0:63];

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Model update at every clock edge / reset assertion.
  initial begin
    bit flushing;
    bit acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        rst_base    = n;
        flush_until = -1;
        streaming   = 1'b0;
        m_vcnt      = 16'd0;
      end else if (!ifc.mac_stall) begin
        flushing = (flush_until >= 0) && (n < flush_until);
        acc      = ifc.in_valid && !flushing;
        n++;
        h_vld[n % 64] = acc;
        h_act[n % 64] = acc ? ifc.in_act : '0;
        h_wt[n % 64]  = acc ? ifc.in_wt  : '0;
        if (acc) begin
          if (!streaming) m_vcnt = 16'd1;
          else if (m_vcnt != 16'hFFFF) m_vcnt = m_vcnt + 16'd1;
          if (ifc.in_last) begin
            streaming   = 1'b0;
            flush_until = n + ARR - 1;
          end else begin
            streaming = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: every cycle, mid-low-phase, DUT against the model.
  initial begin
    logic [W-1:0]   e_act;
    logic [W-1:0]   e_wt;
    logic [ARR-1:0] e_vld;
    bit             flushing;
    int             idx;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        for (int i = 0; i < ARR; i++) begin
          idx = n - i;
          if (idx > rst_base) begin
            e_act[i*DW +: DW] = h_act[idx % 64][i*DW +: DW];
            e_wt[i*DW +: DW]  = h_wt[idx % 64][i*DW +: DW];
            e_vld[i]          = h_vld[idx % 64];
          end else begin
            e_act[i*DW +: DW] = '0;
            e_wt[i*DW +: DW]  = '0;
            e_vld[i]          = 1'b0;
          end
        end
        flushing = (flush_until >= 0) && (n < flush_until);
        chk("act_out", ifc.act_out, e_act);
        chk("wt_out", ifc.wt_out, e_wt);
        chk("lane_valid", W'(ifc.lane_valid), W'(e_vld));
        chk("in_ready", W'(ifc.in_ready), W'(!ifc.mac_stall && !flushing));
        chk("busy", W'(ifc.busy), W'(streaming || flushing));
        chk("tile_done", W'(ifc.tile_done), W'((flush_until >= 0) && (n == flush_until)));
        chk("vec_count", W'(ifc.vec_count), W'(m_vcnt));
      end
    end
  end

  function automatic logic [W-1:0] mkv(input int base);
    logic [W-1:0] r;
    for (int i = 0; i < ARR; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  function automatic logic [W-1:0] rndv();
    logic [W-1:0] r;
    for (int i = 0; i < ARR; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic cyc(input bit v, input bit l, input bit s, input logic [W-1:0] a, input logic [W-1:0] w);
    @(negedge clk);
    ifc.in_valid  = v;
    ifc.in_last   = l;
    ifc.mac_stall = s;
    ifc.in_act    = a;
    ifc.in_wt     = w;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Three-vector tile: lane i of vector v is 10*v+i.
  task automatic tile_a(input string tag);
    for (int v = 0; v < 3; v++) cyc(1'b1, v == 2, 1'b0, mkv(10 * v), mkv(100 * v + 1000));
    idle();
    idle(); #3; chk({tag, "_l3_v0"}, W'(ifc.act_out[3*DW +: DW]), W'(32'd3));
    idle(); #3; chk({tag, "_l3_v1"}, W'(ifc.act_out[3*DW +: DW]), W'(32'd13));
    idle(); #3;
    chk({tag, "_l3_v2"}, W'(ifc.act_out[3*DW +: DW]), W'(32'd23));
    chk({tag, "_wt_l3_v2"}, W'(ifc.wt_out[3*DW +: DW]), W'(32'd1203));
    chk({tag, "_done"}, W'(ifc.tile_done), W'(1'b1));
    chk({tag, "_vcnt"}, W'(ifc.vec_count), W'(16'd3));
    idle(); #3;
    chk({tag, "_done_off"}, W'(ifc.tile_done), W'(1'b0));
    chk({tag, "_vcnt_hold"}, W'(ifc.vec_count), W'(16'd3));
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.mac_stall = 1'b0;
    ifc.in_act    = '0;
    ifc.in_wt     = '0;
    chk_en        = 1'b1;
    repeat (3) idle();
    #3;
    chk("rst_busy", W'(ifc.busy), W'(1'b0));
    chk("rst_vcnt", W'(ifc.vec_count), W'(16'd0));
    chk("rst_lv", W'(ifc.lane_valid), W'(4'b0000));
    idle();
    rst_n = 1'b1;
    #3;
    chk("rel_ready", W'(ifc.in_ready), W'(1'b1));

    tile_a("a");

    // Single-vector tile, then the next tile starts in the tile_done cycle.
    cyc(1'b1, 1'b1, 1'b0, mkv(500), mkv(600));
    idle(); #3;
    chk("b_lv0", W'(ifc.lane_valid), W'(4'b0001));
    chk("b_ready_flush", W'(ifc.in_ready), W'(1'b0));
    idle(); #3; chk("b_lv1", W'(ifc.lane_valid), W'(4'b0010));
    idle(); #3; chk("b_lv2", W'(ifc.lane_valid), W'(4'b0100));
    cyc(1'b1, 1'b0, 1'b0, mkv(700), mkv(800)); #3;
    chk("b_lv3", W'(ifc.lane_valid), W'(4'b1000));
    chk("b_done", W'(ifc.tile_done), W'(1'b1));
    chk("b_ready_done", W'(ifc.in_ready), W'(1'b1));
    chk("b_l3", W'(ifc.act_out[3*DW +: DW]), W'(32'd503));
    cyc(1'b1, 1'b1, 1'b0, mkv(710), mkv(810)); #3;
    chk("b2_vcnt1", W'(ifc.vec_count), W'(16'd1));
    chk("b2_done_off", W'(ifc.tile_done), W'(1'b0));
    idle(); #3;
    chk("b2_vcnt2", W'(ifc.vec_count), W'(16'd2));
    repeat (4) idle();

    // Two-cycle stall mid-stream.
    cyc(1'b1, 1'b0, 1'b0, mkv(900), mkv(950));
    cyc(1'b1, 1'b0, 1'b1, mkv(901), mkv(951)); #3;
    chk("c_ready_stall", W'(ifc.in_ready), W'(1'b0));
    cyc(1'b1, 1'b0, 1'b1, mkv(902), mkv(952)); #3;
    chk("c_frozen_l0", W'(ifc.act_out[0 +: DW]), W'(32'd900));
    cyc(1'b1, 1'b1, 1'b0, mkv(910), mkv(960));
    idle(); idle(); idle(); #3;
    chk("c_done_early", W'(ifc.tile_done), W'(1'b0));
    idle(); #3;
    chk("c_done", W'(ifc.tile_done), W'(1'b1));
    chk("c_l3", W'(ifc.act_out[3*DW +: DW]), W'(32'd913));
    idle();

    // Reset while flushing.
    cyc(1'b1, 1'b0, 1'b0, mkv(1100), mkv(1200));
    cyc(1'b1, 1'b1, 1'b0, mkv(1110), mkv(1210));
    idle();
    idle();
    rst_n = 1'b0;
    #3;
    chk("d_lv", W'(ifc.lane_valid), W'(4'b0000));
    chk("d_act", ifc.act_out, '0);
    chk("d_busy", W'(ifc.busy), W'(1'b0));
    idle();
    idle();
    rst_n = 1'b1;
    repeat (5) idle();
    #3;
    chk("d_no_done", W'(ifc.tile_done), W'(1'b0));
    tile_a("d");

    // Random traffic with stalls, gaps and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 15, rndv(), rndv());
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) idle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

Interface
REQ-001 Parameter ARR_SIZE, default 4: number of systolic lanes; legal range 2..16.
REQ-002 Parameter DATA_W, default 32: width of one operand element.
REQ-003 clk  input  1  single clock for all state; rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a new operand vector pair is presented.
REQ-006 in_ready  output  1  the feeder accepts the vector this cycle.
REQ-007 in_last  input  1  qualifies the presented vector as the last one of the tile.
REQ-008 in_act  input  ARR_SIZE*DATA_W  activation vector; lane i in bits [i*DATA_W +: DATA_W].
REQ-009 in_wt  input  ARR_SIZE*DATA_W  weight vector; same lane packing.
REQ-010 mac_stall  input  1  the MAC array cannot advance; freeze the feeder.
REQ-011 act_out  output  ARR_SIZE*DATA_W  skewed activations to the MAC array edge.
REQ-012 wt_out  output  ARR_SIZE*DATA_W  skewed weights to the MAC array edge.
REQ-013 lane_valid  output  ARR_SIZE  bit i qualifies lane i of act_out/wt_out.
REQ-014 tile_done  output  1  one-cycle pulse: the last element of the tile is on lane ARR_SIZE-1.
REQ-015 busy  output  1  the state is not IDLE.
REQ-016 vec_count  output  16  count of vectors accepted in the current tile.

Function
REQ-017 Advance enable en = !mac_stall; when en is 0, every register, including the FSM, counters, outputs and tile_done, SHALL hold.
REQ-018 in_ready = !mac_stall && state != FLUSH (combinational); accept = in_valid && in_ready.
REQ-019 Lane i SHALL be a shift chain of i+1 registers; an element accepted at enabled edge E appears on lane i after enabled edge E+i.
REQ-020 On an enabled edge without accept, each lane head SHALL load data 0 with valid 0 (a bubble); the skew is preserved.
REQ-021 Act and wt lanes SHALL share one skew, and lane_valid[i] SHALL travel with lane i data.
REQ-022 FSM states: IDLE, STREAM, FLUSH.
REQ-023 IDLE -> STREAM on accept with in_last=0; vec_count <= 1.
REQ-024 IDLE -> FLUSH on accept with in_last=1; vec_count <= 1.
REQ-025 STREAM: each accept increments vec_count, saturating at 16'hFFFF; accept with in_last=1 -> FLUSH.
REQ-026 STREAM with no accept stays in STREAM and inserts bubbles.
REQ-027 FLUSH: load flush_cnt = ARR_SIZE-1 on entry; decrement on each enabled edge while inserting bubbles; no input is accepted.
REQ-028 When flush_cnt reaches 0 on an enabled edge, tile_done SHALL be registered to 1 in the same cycle the last element shows on lane ARR_SIZE-1, and the state returns to IDLE.
REQ-029 tile_done SHALL be exactly one enabled cycle wide; it holds through a stall if asserted.
REQ-030 vec_count holds its final value in IDLE and is overwritten by the first accept of the next tile.
REQ-031 In IDLE, an accept in the same cycle tile_done is high is legal: the new tile starts with no gap cycle.

Reset
REQ-032 While reset is low, the FSM goes to IDLE, all lane data to 0, lane_valid to 0, tile_done to 0, vec_count to 0 and flush_cnt to 0, asynchronously.
REQ-033 Reset mid-tile discards all in-flight elements; no tile_done is issued for the aborted tile.
REQ-034 Outputs after deassertion: in_ready=1 (if mac_stall=0), busy=0.

Verification
REQ-035 ARR_SIZE=4; accept 3 vectors with act lane i = 10*v+i (v=0..2), last on v=2, no stall -> lane 3 shows 3, 13, 23 on cycles E0+3..E0+5; tile_done with the value 23; vec_count=3.
REQ-036 Single-vector tile (in_last on first accept) -> IDLE->FLUSH; 3 bubble cycles; tile_done 3 cycles after accept; lane_valid sequence 0001, 0010, 0100, 1000.
REQ-037 mac_stall=1 for 2 cycles mid-stream -> in_ready=0; outputs frozen bit-exact; the skew is intact after release; tile_done is delayed by exactly 2 cycles.
REQ-038 in_valid gap of 1 cycle in STREAM -> one bubble (lane_valid 0) propagates diagonally; data order is preserved.
REQ-039 reset low during FLUSH -> all outputs 0 immediately; there is no tile_done afterward; the next tile behaves as in REQ-035.
REQ-040 Back-to-back tiles with the next accept in the tile_done cycle -> no lost or duplicated vector; vec_count restarts at 1.
